// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler
// Round-robin packet scheduler sharing one uart_tx serialiser among NUM_REQ
// byte-stream requesters. A requester owns the UART for a whole packet, which
// ends on req_last or after MAX_PKT bytes. An inter-packet gap follows every
// packet. A watchdog aborts a packet that stalls in FETCH or WAIT_DONE.
//
// Ports
//   fpga_clock   in   system clock, rising edge
//   reset_n      in   synchronous active-low reset
//   req_valid    in   per-requester byte valid
//   req_byte     in   per-requester byte, requester i on [8*i+7:8*i]
//   req_last     in   last byte of packet, qualified by valid&ready
//   req_ready    out  byte accepted when req_valid[i] & req_ready[i]
//   grant        out  one-hot UART owner, zero when unowned
//   busy         out  high whenever the FSM is not idle
//   tx_dv        out  uart_tx i_Tx_DV, single-cycle pulse
//   tx_byte      out  uart_tx i_Tx_Byte, held from tx_dv until tx_done
//   tx_active    in   uart_tx o_Tx_Active
//   tx_done      in   uart_tx o_Tx_Done
//   pkt_done     out  pulse on normal packet end
//   timeout_err  out  pulse on watchdog abort
module uart_tx_scheduler #(
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned MAX_PKT    = 16,
  parameter int unsigned GAP_CYCLES = 5208,
  parameter int unsigned TIMEOUT    = 65535
) (
  input  logic                   fpga_clock,
  input  logic                   reset_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [8*NUM_REQ-1:0]   req_byte,
  input  logic [NUM_REQ-1:0]     req_last,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [NUM_REQ-1:0]     grant,
  output logic                   busy,
  output logic                   tx_dv,
  output logic [7:0]             tx_byte,
  input  logic                   tx_active,
  input  logic                   tx_done,
  output logic                   pkt_done,
  output logic                   timeout_err
);

  localparam int unsigned PtrW   = $clog2(NUM_REQ);
  localparam int unsigned CntMax = (TIMEOUT > GAP_CYCLES) ? TIMEOUT : GAP_CYCLES;
  localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax + 1) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StSend,
    StWaitDone,
    StCleanup,
    StGap
  } state_e;

  state_e              r_state, w_state_d;
  logic [NUM_REQ-1:0]  r_grant, w_grant_d;
  logic [PtrW-1:0]     r_rr_ptr, w_rr_ptr_d;
  logic [7:0]          r_byte_cnt, w_byte_cnt_d;
  logic                r_last, w_last_d;
  logic [7:0]          r_tx_byte, w_tx_byte_d;
  // Shared by watchdog and gap timer: both only run within one state and the
  // counter clears on every state change.
  logic [CntW-1:0]     r_cnt, w_cnt_d;

  logic                w_found;
  logic [PtrW-1:0]     w_winner;
  logic                w_sel_valid;
  logic [7:0]          w_sel_byte;
  logic                w_sel_last;
  logic [7:0]          w_byte_cnt_inc;
  logic [31:0]         w_cnt_inc;
  logic                w_wd_expire;
  logic                w_gap_done;
  logic                w_cnt_en;

  // Round-robin search: indices above rr_ptr first, then wrap to 0..rr_ptr.
  always_comb begin
    w_found  = 1'b0;
    w_winner = r_rr_ptr;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (!w_found && req_valid[i] && (PtrW'(i) > r_rr_ptr)) begin
        w_found  = 1'b1;
        w_winner = PtrW'(i);
      end
    end
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (!w_found && req_valid[i] && (PtrW'(i) <= r_rr_ptr)) begin
        w_found  = 1'b1;
        w_winner = PtrW'(i);
      end
    end
  end

  // Mux of the granted requester; grant is one-hot or zero.
  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_byte  = 8'h00;
    w_sel_last  = 1'b0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (r_grant[i]) begin
        w_sel_valid = req_valid[i];
        w_sel_byte  = req_byte[8*i +: 8];
        w_sel_last  = req_last[i];
      end
    end
  end

  assign w_byte_cnt_inc = r_byte_cnt + 8'd1;
  assign w_cnt_inc      = 32'(r_cnt) + 32'd1;
  assign w_wd_expire    = (w_cnt_inc == TIMEOUT);
  // Also true for GAP_CYCLES == 0, so the gap collapses to a single cycle.
  assign w_gap_done     = (w_cnt_inc >= GAP_CYCLES);

  always_comb begin
    w_state_d    = r_state;
    w_grant_d    = r_grant;
    w_rr_ptr_d   = r_rr_ptr;
    w_byte_cnt_d = r_byte_cnt;
    w_last_d     = r_last;
    w_tx_byte_d  = r_tx_byte;
    w_cnt_en     = 1'b0;
    tx_dv        = 1'b0;
    pkt_done     = 1'b0;
    timeout_err  = 1'b0;

    unique case (r_state)
      StIdle: begin
        if (w_found) begin
          for (int i = 0; i < int'(NUM_REQ); i++) begin
            w_grant_d[i] = (PtrW'(i) == w_winner);
          end
          w_rr_ptr_d   = w_winner;
          w_byte_cnt_d = 8'h00;
          w_state_d    = StFetch;
        end
      end
      StFetch: begin
        if (w_sel_valid) begin
          w_tx_byte_d  = w_sel_byte;
          w_last_d     = w_sel_last | (w_byte_cnt_inc == 8'(MAX_PKT));
          w_byte_cnt_d = w_byte_cnt_inc;
          w_state_d    = StSend;
        end else if (w_wd_expire) begin
          timeout_err = 1'b1;
          w_grant_d   = '0;
          w_state_d   = StGap;
        end else begin
          w_cnt_en = 1'b1;
        end
      end
      StSend: begin
        tx_dv     = 1'b1;
        w_state_d = StWaitDone;
      end
      StWaitDone: begin
        // tx_done wins over a simultaneous watchdog expiry.
        if (tx_done) begin
          w_state_d = StCleanup;
        end else if (w_wd_expire) begin
          timeout_err = 1'b1;
          w_grant_d   = '0;
          w_state_d   = StGap;
        end else begin
          w_cnt_en = 1'b1;
        end
      end
      StCleanup: begin
        if (r_last) begin
          pkt_done  = 1'b1;
          w_grant_d = '0;
          w_state_d = StGap;
        end else begin
          w_state_d = StFetch;
        end
      end
      StGap: begin
        if (w_gap_done && !tx_active) begin
          w_state_d = StIdle;
        end else if (!w_gap_done) begin
          w_cnt_en = 1'b1;
        end
      end
      default: begin
        w_grant_d = '0;
        w_state_d = StIdle;
      end
    endcase

    if (w_state_d != r_state) begin
      w_cnt_d = '0;
    end else if (w_cnt_en) begin
      w_cnt_d = r_cnt + CntW'(1);
    end else begin
      w_cnt_d = r_cnt;
    end
  end

  always_ff @(posedge fpga_clock) begin
    if (!reset_n) begin
      r_state    <= StIdle;
      r_grant    <= '0;
      r_rr_ptr   <= PtrW'(NUM_REQ - 1);
      r_byte_cnt <= 8'h00;
      r_last     <= 1'b0;
      r_tx_byte  <= 8'h00;
      r_cnt      <= '0;
    end else begin
      r_state    <= w_state_d;
      r_grant    <= w_grant_d;
      r_rr_ptr   <= w_rr_ptr_d;
      r_byte_cnt <= w_byte_cnt_d;
      r_last     <= w_last_d;
      r_tx_byte  <= w_tx_byte_d;
      r_cnt      <= w_cnt_d;
    end
  end

  assign req_ready = (r_state == StFetch) ? r_grant : '0;
  assign grant     = r_grant;
  assign busy      = (r_state != StIdle);
  assign tx_byte   = r_tx_byte;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
module tb_uart_tx_scheduler;

  localparam int CPB   = 4;
  localparam int BOUND = 2000;

  logic        fpga_clock;
  logic        reset_n;
  logic [1:0]  req_valid;
  logic [15:0] req_byte;
  logic [1:0]  req_last;
  logic [1:0]  req_ready;
  logic [1:0]  grant;
  logic        busy;
  logic        tx_dv;
  logic [7:0]  tx_byte;
  logic        tx_active;
  logic        tx_done;
  logic        pkt_done;
  logic        timeout_err;

  logic        p_valid [2];
  logic [7:0]  p_byte  [2];
  logic        p_last  [2];

  assign req_valid = {p_valid[1], p_valid[0]};
  assign req_byte  = {p_byte[1], p_byte[0]};
  assign req_last  = {p_last[1], p_last[0]};

  uart_tx_scheduler #(
    .NUM_REQ    (2),
    .MAX_PKT    (4),
    .GAP_CYCLES (3),
    .TIMEOUT    (100)
  ) dut (
    .fpga_clock  (fpga_clock),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_byte    (req_byte),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .grant       (grant),
    .busy        (busy),
    .tx_dv       (tx_dv),
    .tx_byte     (tx_byte),
    .tx_active   (tx_active),
    .tx_done     (tx_done),
    .pkt_done    (pkt_done),
    .timeout_err (timeout_err)
  );

  initial fpga_clock = 1'b0;
  always #5 fpga_clock = ~fpga_clock;

  // Behavioural uart_tx: start bit, 8 data bits LSB first, stop bit, CPB clocks
  // each. The frame reads tx_byte live, so an unstable tx_byte shows on serial.
  logic       m_busy;
  logic [3:0] m_bit;
  logic [1:0] m_cnt;
  logic       m_done;
  logic       stub_done;
  logic [9:0] frame;
  logic       serial;

  assign frame     = {1'b1, tx_byte, 1'b0};
  assign serial    = m_busy ? frame[m_bit] : 1'b1;
  assign tx_active = m_busy;
  assign tx_done   = m_done;

  always @(posedge fpga_clock) begin
    if (!reset_n) begin
      m_busy <= 1'b0;
      m_bit  <= 4'd0;
      m_cnt  <= 2'd0;
      m_done <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (!m_busy) begin
        if (tx_dv) begin
          m_busy <= 1'b1;
          m_bit  <= 4'd0;
          m_cnt  <= 2'd0;
        end
      end else if (m_cnt == 2'(CPB - 1)) begin
        m_cnt <= 2'd0;
        if (m_bit == 4'd9) begin
          m_busy <= 1'b0;
          m_done <= !stub_done;
        end else begin
          m_bit <= m_bit + 4'd1;
        end
      end else begin
        m_cnt <= m_cnt + 2'd1;
      end
    end
  end

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", name, got, exp);
    end
  endtask

  // Monitor: logs every byte handed to the UART and counts result pulses.
  logic [7:0] log_byte [$];
  logic [1:0] log_gnt  [$];
  int         pkt_cnt = 0;
  int         to_cnt  = 0;

  always @(negedge fpga_clock) begin
    if (reset_n) begin
      if (tx_dv) begin
        log_byte.push_back(tx_byte);
        log_gnt.push_back(grant);
        check("ready_low_in_send", 32'(req_ready), 32'h0);
        check("grant_onehot_in_send", $countones(grant), 32'd1);
      end
      if (pkt_done) pkt_cnt++;
      if (timeout_err) to_cnt++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge fpga_clock);
  endtask

  // Presents n bytes from requester r; byte last_idx carries last.
  task automatic send_pkt(input int r, input int n, input logic [7:0] b0, input int last_idx);
    for (int i = 0; i < n; i++) begin
      int t;
      p_valid[r] = 1'b1;
      p_byte[r]  = b0 + 8'(i);
      p_last[r]  = (i == last_idx);
      t = 0;
      while (!req_ready[r] && t < BOUND) begin
        tick(1);
        t++;
      end
      if (t == BOUND) begin
        check("ready_wait", 32'd0, 32'd1);
        p_valid[r] = 1'b0;
        return;
      end
      tick(1);
    end
    p_valid[r] = 1'b0;
    p_last[r]  = 1'b0;
  endtask

  int li = 0;

  task automatic check_log(input logic [7:0] exp_b, input logic [1:0] exp_g);
    int t;
    t = 0;
    while (log_byte.size() <= li && t < BOUND) begin
      tick(1);
      t++;
    end
    if (t == BOUND) begin
      check("log_wait", 32'd0, 32'd1);
      return;
    end
    check("log_byte", 32'(log_byte[li]), 32'(exp_b));
    check("log_grant", 32'(log_gnt[li]), 32'(exp_g));
    li++;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (busy && t < BOUND) begin
      tick(1);
      t++;
    end
    check("idle_reached", 32'(busy), 32'd0);
  endtask

  task automatic check_counts(input int exp_pkt, input int exp_to);
    int t;
    t = 0;
    while ((pkt_cnt < exp_pkt || to_cnt < exp_to) && t < BOUND) begin
      tick(1);
      t++;
    end
    check("pkt_done_count", 32'(pkt_cnt), 32'(exp_pkt));
    check("timeout_count", 32'(to_cnt), 32'(exp_to));
  endtask

  task automatic check_reset_outputs();
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_ready", 32'(req_ready), 32'h0);
    check("rst_tx_dv", 32'(tx_dv), 32'h0);
    check("rst_tx_byte", 32'(tx_byte), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_pkt_done", 32'(pkt_done), 32'h0);
    check("rst_timeout", 32'(timeout_err), 32'h0);
  endtask

  initial begin
    int         k;
    logic [9:0] bits;

    reset_n   = 1'b0;
    stub_done = 1'b0;
    for (int i = 0; i < 2; i++) begin
      p_valid[i] = 1'b0;
      p_byte[i]  = 8'h00;
      p_last[i]  = 1'b0;
    end
    tick(3);
    check_reset_outputs();
    reset_n = 1'b1;
    tick(1);
    check("idle_after_reset", 32'(busy), 32'd0);

    // 1: single byte A5 from req0, latency, serial frame, gap length
    p_valid[0] = 1'b1;
    p_byte[0]  = 8'hA5;
    p_last[0]  = 1'b1;
    tick(1);
    check("t1_grant", 32'(grant), 32'h1);
    check("t1_ready", 32'(req_ready), 32'h1);
    check("t1_no_dv_yet", 32'(tx_dv), 32'd0);
    tick(1);
    check("t1_tx_dv", 32'(tx_dv), 32'd1);
    check("t1_tx_byte", 32'(tx_byte), 32'hA5);
    p_valid[0] = 1'b0;
    p_last[0]  = 1'b0;
    tick(2);
    bits[0] = serial;
    for (int b = 1; b < 10; b++) begin
      tick(CPB);
      bits[b] = serial;
      if (b == 4) check("t1_byte_held", 32'(tx_byte), 32'hA5);
    end
    check("t1_serial_frame", 32'(bits), 32'(10'b1101001010));
    k = 0;
    while (!pkt_done && k < BOUND) begin
      tick(1);
      k++;
    end
    check("t1_pkt_done_seen", 32'(pkt_done), 32'd1);
    tick(3);
    check("t1_busy_in_gap", 32'(busy), 32'd1);
    tick(1);
    check("t1_busy_after_gap", 32'(busy), 32'd0);
    check_log(8'hA5, 2'b01);
    check_counts(1, 0);

    // 2: contention; req0 first after reset, then req1, then req0's 2nd packet
    reset_n = 1'b0;
    tick(1);
    reset_n = 1'b1;
    tick(1);
    fork
      begin
        send_pkt(0, 2, 8'h10, 1);
        send_pkt(0, 2, 8'h30, 1);
      end
      send_pkt(1, 2, 8'h20, 1);
    join
    check_log(8'h10, 2'b01);
    check_log(8'h11, 2'b01);
    check_log(8'h20, 2'b10);
    check_log(8'h21, 2'b10);
    check_log(8'h30, 2'b01);
    check_log(8'h31, 2'b01);
    check_counts(4, 0);
    wait_idle();

    // 3: 6-byte stream from req1 splits at MAX_PKT=4
    send_pkt(1, 6, 8'h40, 5);
    for (int i = 0; i < 6; i++) check_log(8'h40 + 8'(i), 2'b10);
    check_counts(6, 0);
    wait_idle();

    // 4: req0 stalls after one byte; watchdog in FETCH; req1 served after
    p_valid[0] = 1'b1;
    p_byte[0]  = 8'h55;
    p_last[0]  = 1'b0;
    k = 0;
    while (!req_ready[0] && k < BOUND) begin
      tick(1);
      k++;
    end
    tick(1);
    p_valid[0]  = 1'b0;
    p_valid[1]  = 1'b1;
    p_byte[1]   = 8'h66;
    p_last[1]   = 1'b1;
    k = 0;
    while (!req_ready[0] && k < BOUND) begin
      tick(1);
      k++;
    end
    k = 1;
    while (!timeout_err && k < BOUND) begin
      tick(1);
      k++;
    end
    check("t4_fetch_timeout_clks", 32'(k), 32'd100);
    tick(1);
    check("t4_grant_cleared", 32'(grant), 32'h0);
    check("t4_ready_cleared", 32'(req_ready), 32'h0);
    send_pkt(1, 1, 8'h66, 0);
    check_log(8'h55, 2'b01);
    check_log(8'h66, 2'b10);
    check_counts(7, 1);
    wait_idle();

    // 5: tx_done never arrives; watchdog in WAIT_DONE
    stub_done  = 1'b1;
    p_valid[0] = 1'b1;
    p_byte[0]  = 8'h77;
    p_last[0]  = 1'b1;
    k = 0;
    while (!tx_dv && k < BOUND) begin
      tick(1);
      k++;
    end
    p_valid[0] = 1'b0;
    p_last[0]  = 1'b0;
    k = 0;
    while (!timeout_err && k < BOUND) begin
      tick(1);
      k++;
    end
    check("t5_wait_timeout_clks", 32'(k), 32'd100);
    tick(3);
    check("t5_busy_in_gap", 32'(busy), 32'd1);
    tick(1);
    check("t5_idle_after_gap", 32'(busy), 32'd0);
    stub_done = 1'b0;
    check_log(8'h77, 2'b01);
    check_counts(7, 2);

    // 6: reset during WAIT_DONE, then a normal packet
    send_pkt(1, 1, 8'h88, 0);
    tick(5);
    check("t6_busy_before_reset", 32'(busy), 32'd1);
    reset_n = 1'b0;
    tick(1);
    check_reset_outputs();
    reset_n = 1'b1;
    send_pkt(0, 1, 8'h99, 0);
    check_log(8'h88, 2'b10);
    check_log(8'h99, 2'b01);
    check_counts(8, 2);
    wait_idle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
